// File: rtl/expr_str_if.sv
// Character stream link: one 8-bit ASCII char per cycle where char_valid and ready are both high.
interface expr_str_if;
   logic [7:0] char;
   logic       char_valid;
   logic       ready;

   modport master (output char, char_valid, input ready);
   modport slave  (input char, char_valid, output ready);
endinterface

// File: rtl/expr_str_tx.sv
// Serialises a latched digit/operator request into ASCII chars, e.g. "1*2*3"; first char one cycle after start.
// 2N-1 chars at one per cycle while ready=1; ready=0 freezes char/char_valid and all state.
module expr_str_tx #(
   parameter int         MAX_TERMS = 8,
   parameter logic [7:0] OP0_CHAR  = 8'h2A,
   parameter logic [7:0] OP1_CHAR  = 8'h2B,
   parameter logic [7:0] IDLE_CHAR = 8'h00
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   start,
   input  logic [3:0]             n_terms,
   input  logic [4*MAX_TERMS-1:0] digits,
   input  logic [MAX_TERMS-2:0]   ops,
   expr_str_if.master             tx,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   typedef enum logic [1:0] {IDLE, DIGIT, OP} state_t;

   state_t      state_q, state_n;
   logic [3:0]  idx_q, idx_n;
   logic [3:0]  n_q;
   // Latched copies padded to the 4-bit index range so idx can address them directly.
   logic [63:0] dig_q;
   logic [15:0] ops_q;
   logic [7:0]  char_q, char_n;
   logic        vld_q, vld_n;
   logic        busy_n, done_n, err_n;
   logic        latch;
   logic        bad_req;
   logic [3:0]  idx_p1;

   always_comb begin
      bad_req = (n_terms == 4'd0) || (n_terms > 4'(MAX_TERMS));
      for (int k = 0; k < MAX_TERMS; k++) begin
         if ((k < int'(n_terms)) && (digits[4*k +: 4] > 4'd9))
            bad_req = 1'b1;
      end
   end

   assign idx_p1 = idx_q + 4'd1;

   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      char_n  = char_q;
      vld_n   = vld_q;
      busy_n  = busy;
      done_n  = 1'b0;
      err_n   = 1'b0;
      latch   = 1'b0;
      case (state_q)
         IDLE: begin
            vld_n  = 1'b0;
            char_n = IDLE_CHAR;
            busy_n = 1'b0;
            if (start) begin
               if (bad_req) begin
                  err_n = 1'b1;
               end else begin
                  latch   = 1'b1;
                  state_n = DIGIT;
                  idx_n   = 4'd0;
                  busy_n  = 1'b1;
                  vld_n   = 1'b1;
                  char_n  = 8'h30 + {4'd0, digits[3:0]};
               end
            end
         end
         DIGIT: begin
            if (tx.ready) begin
               if (idx_q == n_q - 4'd1) begin
                  state_n = IDLE;
                  vld_n   = 1'b0;
                  char_n  = IDLE_CHAR;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  state_n = OP;
                  char_n  = ops_q[idx_q] ? OP1_CHAR : OP0_CHAR;
               end
            end
         end
         OP: begin
            if (tx.ready) begin
               state_n = DIGIT;
               idx_n   = idx_p1;
               char_n  = 8'h30 + {4'd0, dig_q[{idx_p1, 2'b00} +: 4]};
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         n_q     <= 4'd0;
         dig_q   <= 64'd0;
         ops_q   <= 16'd0;
         char_q  <= IDLE_CHAR;
         vld_q   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         char_q  <= char_n;
         vld_q   <= vld_n;
         busy    <= busy_n;
         done    <= done_n;
         err     <= err_n;
         if (latch) begin
            n_q   <= n_terms;
            dig_q <= 64'(digits);
            ops_q <= 16'(ops);
         end
      end
   end

   assign tx.char       = char_q;
   assign tx.char_valid = vld_q;

endmodule
